frame_writer_18bit: RTL and testbench

Output-side frame writer for the decompressor datapath. It accepts a byte stream over a valid/ready handshake and writes the bytes to sequential addresses of an 18-bit-addressed frame memory. A frame is two header bytes followed by a YUV 4:2:0 payload of width*height*3/2 bytes. The block is the write-side counterpart of the 18-bit read-address counter that streams stored frames out of memory.

---
 rtl/frame_writer_18bit.sv | 115 +++++++++++
 tb/tb_frame_writer_18bit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_writer_18bit.sv
// Frame writer: accepts a header+YUV420 byte stream over valid/ready and
// writes it to sequential addresses of an 18-bit-addressed frame memory.
module frame_writer_18bit #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear,
  input  logic [15:0]       width,
  input  logic [15:0]       height,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] count,
  output logic [ADDR_W-1:0] total,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [34:0] MAX_LEN = 35'(1) << ADDR_W;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]   total_q, total_d;
  logic                err_q, err_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic [34:0]         prod_full;
  logic [34:0]         total_full;
  logic                size_ok;

  // Full-width length so huge width*height products cannot alias into range.
  assign prod_full  = 35'(width) * 35'(height) * 35'd3;
  assign total_full = (prod_full >> 1) + 35'd2;
  assign size_ok    = (width != 16'd0) && (height != 16'd0) && (total_full <= MAX_LEN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      total_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      total_q <= total_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    total_d = total_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            if (!size_ok) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end else begin
              err_d   = 1'b0;
              total_d = total_full[ADDR_W-1:0];
              count_d = '0;
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (in_valid) begin
            we_d    = 1'b1;
            addr_d  = count_q;
            data_d  = in_data;
            count_d = count_q + 1'b1;
            // total of 2^18 is stored as 0; total-1 wraps to the last address.
            if (count_q == total_q - 1'b1) state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign in_ready = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign mem_we   = we_q;
  assign mem_addr = addr_q;
  assign mem_data = data_q;
  assign count    = count_q;
  assign total    = total_q;
  assign err      = err_q;

endmodule

// File: tb/tb_frame_writer_18bit.sv
// Scoreboard bench for frame_writer_18bit: a frame-level reference model
// predicts each memory write; a negedge monitor compares what the DUT emits.
module tb_frame_writer_18bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] width = '0;
  logic [15:0] height = '0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, mem_we, done, err;
  logic [17:0] mem_addr, count, total;
  logic [7:0]  mem_data;

  int checks = 0;
  int failures = 0;

  logic [25:0] exp_q[$];

  // Reference model: plain frame bookkeeping.
  bit     m_run = 0;
  bit     m_done = 0;
  bit     m_err = 0;
  longint m_count = 0;
  longint m_total = 0;

  frame_writer_18bit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .clear    (clear),
    .width    (width),
    .height   (height),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .count    (count),
    .total    (total),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%0d data=%0h required=no write", mem_addr, mem_data);
      end else begin
        logic [25:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_data} !== e) begin
          failures++;
          $display("FAIL write actual addr=%0d data=%0h required addr=%0d data=%0h",
                   mem_addr, mem_data, e[25:8], e[7:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic check_outputs();
    chk("in_ready", longint'(in_ready), longint'(m_run));
    chk("done", longint'(done), longint'(m_done));
    chk("count", longint'(count), m_count);
    chk("total", longint'(total), m_total % 262144);
    chk("err", longint'(err), longint'(m_err));
  endtask

  // Applies the current inputs for one clock edge, advancing the model first.
  task automatic step();
    longint tf;
    chk("in_ready_pre", longint'(in_ready), longint'(m_run));
    if (clear) begin
      m_run = 0;
      m_done = 0;
    end else if (!m_run && start) begin
      tf = (longint'(width) * longint'(height) * 3) / 2 + 2;
      m_done = 0;
      if (width == 0 || height == 0 || tf > 262144) begin
        m_err = 1;
      end else begin
        m_err = 0;
        m_total = tf;
        m_count = 0;
        m_run = 1;
      end
    end else if (m_run && in_valid) begin
      exp_q.push_back({18'(m_count), in_data});
      m_count++;
      if (m_count == m_total) begin
        m_run = 0;
        m_done = 1;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
    start = 1'b0;
    clear = 1'b0;
  endtask

  task automatic start_frame(input int w, input int h);
    width = 16'(w);
    height = 16'(h);
    start = 1'b1;
    in_valid = 1'b0;
    step();
  endtask

  // gap: 0 = back-to-back, 1 = valid pattern 1,0,0, 2 = random.
  task automatic send(input int nbytes, input int gap, input bit data_is_addr);
    int sent = 0;
    int cyc = 0;
    while (sent < nbytes && cyc < 4000) begin
      case (gap)
        0: in_valid = 1'b1;
        1: in_valid = (cyc % 3 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = data_is_addr ? 8'(m_count) : 8'($urandom);
      if (in_valid) sent++;
      step();
      cyc++;
    end
    if (sent < nbytes) chk("send_budget", sent, nbytes);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset_values();
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_mem_we", longint'(mem_we), 0);
    chk("rst_mem_addr", longint'(mem_addr), 0);
    chk("rst_mem_data", longint'(mem_data), 0);
    chk("rst_count", longint'(count), 0);
    chk("rst_total", longint'(total), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_err", longint'(err), 0);
  endtask

  // Asynchronous reset away from any clock edge, after the monitor has sampled.
  task automatic async_reset();
    in_valid = 1'b0;
    #5;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    #1;
    rst_n = 1'b1;
    m_run = 0;
    m_done = 0;
    m_err = 0;
    m_count = 0;
    m_total = 0;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    #2;
    check_reset_values();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();

    // Basic frame 4x2, data equal to address.
    start_frame(4, 2);
    chk("basic_total", longint'(total), 14);
    send(14, 0, 1'b1);
    idle(1);

    // Odd size 3x3: 15 bytes, then an extra valid is refused.
    start_frame(3, 3);
    chk("odd_total", longint'(total), 15);
    send(16, 0, 1'b0);
    idle(2);

    // Size errors, then a valid start clears err.
    start_frame(512, 512);
    chk("err_512", longint'(err), 1);
    start_frame(0, 8);
    chk("err_zero", longint'(err), 1);
    start_frame(65535, 65535);
    start_frame(6, 29127);
    chk("err_just_over", longint'(err), 1);
    idle(2);
    start_frame(4, 2);
    chk("err_cleared", longint'(err), 0);
    send(14, 2, 1'b0);
    idle(1);

    // Backpressure gaps on 2x2.
    start_frame(2, 2);
    send(8, 1, 1'b0);
    idle(2);

    // Clear after 5 bytes, coincident with a valid byte.
    start_frame(4, 2);
    send(5, 0, 1'b0);
    in_valid = 1'b1;
    in_data = 8'hA5;
    clear = 1'b1;
    step();
    chk("clear_count", longint'(count), 5);
    send(3, 0, 1'b0);
    idle(1);

    // Reset mid-frame after 3 bytes.
    start_frame(4, 2);
    send(3, 0, 1'b0);
    async_reset();
    idle(2);

    // Largest accepted size near the 2^18 limit, then aborted.
    start_frame(8, 21845);
    chk("big_total", longint'(total), 262142);
    send(3, 2, 1'b0);
    clear = 1'b1;
    step();
    idle(1);

    // Restart from DONE.
    start_frame(4, 2);
    send(14, 0, 1'b0);
    chk("done_high", longint'(done), 1);
    start_frame(2, 2);
    chk("done_dropped", longint'(done), 0);
    send(8, 0, 1'b1);
    idle(1);

    // Random small frames with random gaps, start pulses in RUN ignored.
    for (int f = 0; f < 6; f++) begin
      int w = $urandom_range(1, 7);
      int h = $urandom_range(1, 6);
      start_frame(w, h);
      send(2, 2, 1'b0);
      width = 16'd1;
      height = 16'd1;
      start = 1'b1;
      step();
      send(w * h * 3 / 2 + 2, 2, 1'b0);
      idle(1);
    end

    idle(2);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
